// File: rtl/ha_bist_pkg.sv
// rtl/ha_bist_pkg.sv - shared state enum and constants for the half adder BIST
package ha_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_e;

  localparam int unsigned NUM_PATTERNS = 4;
  localparam int unsigned SETTLE_MIN   = 1;
  localparam int unsigned SETTLE_MAX   = 15;

  localparam logic [1:0] LAST_IDX = 2'(NUM_PATTERNS - 1);
  localparam logic [2:0] ERR_MAX  = 3'd7;

  // Last value of the WAIT counter; out-of-range settle counts are clamped
  // so the counter can never run past its 4-bit range.
  function automatic logic [3:0] settle_last(int unsigned n);
    int unsigned c;
    c = (n < SETTLE_MIN) ? SETTLE_MIN : ((n > SETTLE_MAX) ? SETTLE_MAX : n);
    return 4'(c - 1);
  endfunction

endpackage

// File: rtl/halfadder.sv
// rtl/halfadder.sv - reference half adder used as the BIST golden model
module halfadder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b;
  assign cout = a & b;

endmodule

// File: rtl/halfadder_bist.sv
// rtl/halfadder_bist.sv - exhaustive 4-pattern BIST for a half adder; HA_BIST_LOOP_EN adds looping runs
module halfadder_bist
  import ha_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
`ifdef HA_BIST_LOOP_EN
  input  logic       loop,
`endif
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_sum,
  input  logic       dut_cout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam logic [3:0] WAIT_LAST = settle_last(SETTLE_CYCLES);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       dut_a_q, dut_a_d;
  logic       dut_b_q, dut_b_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fail_q, fail_d;

  logic       exp_sum;
  logic       exp_cout;
  logic       mismatch;

  // Golden model sees exactly the operands presented to the device.
  halfadder u_golden (
    .a    (dut_a_q),
    .b    (dut_b_q),
    .sum  (exp_sum),
    .cout (exp_cout)
  );

  // State and result registers; reset aborts any run without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      wait_cnt_q <= 4'd0;
      dut_a_q    <= 1'b0;
      dut_b_q    <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= 3'd0;
      fail_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wait_cnt_q <= wait_cnt_d;
      dut_a_q    <= dut_a_d;
      dut_b_q    <= dut_b_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      fail_q     <= fail_d;
    end
  end

  // Next-state logic: drive pattern, let it settle, compare, advance.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wait_cnt_d = wait_cnt_q;
    dut_a_d    = dut_a_q;
    dut_b_d    = dut_b_q;
    pass_d     = pass_q;
    err_d      = err_q;
    fail_d     = fail_q;
    mismatch   = (dut_sum != exp_sum) || (dut_cout != exp_cout);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DRIVE;
          idx_d   = 2'd0;
          err_d   = 3'd0;
          fail_d  = 4'd0;
          pass_d  = 1'b0;
        end
      end
      ST_DRIVE: begin
        dut_a_d    = idx_q[1];
        dut_b_d    = idx_q[0];
        wait_cnt_d = 4'd0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_CHECK;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      ST_CHECK: begin
        // Saturation only matters when looping; a single run tops out at 4.
        if (mismatch) begin
          fail_d[idx_q] = 1'b1;
          if (err_q != ERR_MAX) begin
            err_d = err_q + 3'd1;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          pass_d  = (err_d == 3'd0);
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = ST_DRIVE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef HA_BIST_LOOP_EN
        if (loop) begin
          state_d = ST_DRIVE;
          idx_d   = 2'd0;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign dut_a     = dut_a_q;
  assign dut_b     = dut_b_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_halfadder_bist.sv
// tb/tb_halfadder_bist.sv - directed self-checking bench for halfadder_bist
module tb_halfadder_bist;

  localparam int S       = 2;
  localparam int PER     = S + 2;
  localparam int DONE_K  = 4 * PER + 1;
`ifdef HA_BIST_LOOP_EN
  localparam bit LOOP_BUILD = 1'b1;
`else
  localparam bit LOOP_BUILD = 1'b0;
`endif

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       pass;
    logic       a;
    logic       b;
    logic [2:0] err;
    logic [3:0] fail;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       loop_drv;
  logic       dut_a, dut_b, dut_sum, dut_cout;
  logic       busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;
  int         fault;

  int   n_vec  = 0;
  int   n_miss = 0;

  int   m_k;
  int   m_run;
  exp_t hold;
  exp_t exp_o;

  always #5 clk = ~clk;

  halfadder_bist #(.SETTLE_CYCLES(S)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef HA_BIST_LOOP_EN
    .loop      (loop_drv),
`endif
    .dut_a     (dut_a),
    .dut_b     (dut_b),
    .dut_sum   (dut_sum),
    .dut_cout  (dut_cout),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec)
  );

  // Device under test: a half adder with selectable stuck/inverted faults.
  function automatic logic [1:0] dev(int mode, logic a, logic b);
    case (mode)
      1:       return {1'b0, a & b};
      2:       return {a ^ b, 1'b1};
      3:       return {~(a ^ b), a & b};
      4:       return {a ^ b, 1'b0};
      default: return {a ^ b, a & b};
    endcase
  endfunction

  assign {dut_sum, dut_cout} = dev(fault, dut_a, dut_b);

  // Expected outputs k cycles after a start was accepted (k=0: idle).
  function automatic exp_t model_eval(int k, int run, int mode, exp_t h);
    exp_t       e;
    int         cur, p, ph, errs, nbad;
    logic [1:0] jj, r, pat;
    e      = h;
    e.busy = (k != 0);
    e.done = (k == DONE_K);
    if (k != 0) begin
      cur  = (k - 1) / PER;
      errs = 0;
      nbad = 0;
      e.fail = 4'd0;
      for (int j = 0; j < 4; j++) begin
        jj = 2'(j);
        r  = dev(mode, jj[1], jj[0]);
        if (r != {jj[1] ^ jj[0], jj[1] & jj[0]}) begin
          nbad++;
          if (j < cur) errs++;
          if (run > 0 || j < cur) e.fail[j] = 1'b1;
        end
      end
      errs  = errs + run * nbad;
      e.err = (errs > 7) ? 3'd7 : 3'(errs);
      if (e.done) e.pass = (errs == 0);
      else if (k == 1 && run == 0) e.pass = 1'b0;
      p  = (k - 1) / PER;
      ph = (k - 1) % PER;
      if (ph == 0) begin
        if (p > 0) begin
          pat = 2'(p - 1);
          e.a = pat[1];
          e.b = pat[0];
        end
      end else begin
        pat = 2'(p);
        e.a = pat[1];
        e.b = pat[0];
      end
    end
    return e;
  endfunction

  assign exp_o = model_eval(m_k, m_run, fault, hold);

  // Model timeline: cycles since start, run number, held outputs.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k   <= 0;
      m_run <= 0;
      hold  <= '0;
    end else begin
      hold <= exp_o;
      if (m_k == 0) begin
        m_k   <= start ? 1 : 0;
        m_run <= 0;
      end else if (m_k == DONE_K) begin
        if (loop_drv && LOOP_BUILD) begin
          m_k   <= 1;
          m_run <= m_run + 1;
        end else begin
          m_k <= 0;
        end
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    chk("busy", busy, exp_o.busy);
    chk("done", done, exp_o.done);
    chk("pass", pass, exp_o.pass);
    chk("dut_a", dut_a, exp_o.a);
    chk("dut_b", dut_b, exp_o.b);
    chk("err_count", err_count, exp_o.err);
    chk("fail_vec", fail_vec, exp_o.fail);
  endtask

  task automatic run_check(input string tag, input int mode, input bit repulse,
                           input logic ep, input logic [2:0] ee, input logic [3:0] ef);
    int lat, ndone;
    fault = mode;
    start = 1'b1;
    lat   = 0;
    ndone = 0;
    while (!done && lat < 60) begin
      cycle();
      lat++;
      if (lat == 1) start = 1'b0;
      if (repulse && lat == 5) start = 1'b1;
      if (repulse && lat == 6) start = 1'b0;
      if (done) ndone++;
    end
    chk({tag, "_latency"}, lat, 17);
    chk({tag, "_pass"}, pass, ep);
    chk({tag, "_err"}, err_count, ee);
    chk({tag, "_fail"}, fail_vec, ef);
    chk({tag, "_model_err"}, exp_o.err, ee);
    repeat (3) begin
      cycle();
      if (done) ndone++;
    end
    chk({tag, "_done_pulses"}, ndone, 1);
  endtask

  initial begin
    int t, first, second, nd;
    rst      = 1'b1;
    start    = 1'b0;
    loop_drv = 1'b0;
    fault    = 0;
    repeat (2) cycle();
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_count, 3'd0);
    chk("rst_fail", fail_vec, 4'd0);
    rst = 1'b0;
    repeat (2) cycle();

    run_check("good",    0, 1'b0, 1'b1, 3'd0, 4'b0000);
    run_check("sum0",    1, 1'b0, 1'b0, 3'd2, 4'b0110);
    run_check("cout1",   2, 1'b0, 1'b0, 3'd3, 4'b0111);
    run_check("suminv",  3, 1'b0, 1'b0, 3'd4, 4'b1111);
    run_check("cout0",   4, 1'b0, 1'b0, 3'd1, 4'b1000);
    run_check("repulse", 0, 1'b1, 1'b1, 3'd0, 4'b0000);

    // Reset during WAIT of pattern 2 (k=10) with a partially failed run.
    fault = 1;
    start = 1'b1;
    t     = 0;
    while (t < 10) begin
      cycle();
      t++;
      if (t == 1) start = 1'b0;
    end
    chk("prerst_err", err_count, 3'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_pass", pass, 1'b0);
    chk("midrst_err", err_count, 3'd0);
    chk("midrst_fail", fail_vec, 4'd0);
    chk("midrst_ab", {dut_a, dut_b}, 2'b00);
    repeat (2) cycle();
    rst = 1'b0;
    nd  = 0;
    repeat (20) begin
      cycle();
      if (done) nd++;
    end
    chk("aborted_done_pulses", nd, 0);
    run_check("after_rst", 0, 1'b0, 1'b1, 3'd0, 4'b0000);

    // Start held high relaunches the cycle after DONE.
    fault  = 0;
    start  = 1'b1;
    t      = 0;
    first  = -1;
    second = -1;
    while (second < 0 && t < 100) begin
      cycle();
      t++;
      if (done) begin
        if (first < 0) first = t;
        else second = t;
      end
    end
    start = 1'b0;
    chk("relaunch_gap", second - first, 18);
    repeat (2) cycle();

`ifdef HA_BIST_LOOP_EN
    fault    = 1;
    loop_drv = 1'b1;
    start    = 1'b1;
    t        = 0;
    nd       = 0;
    while (nd < 3 && t < 200) begin
      cycle();
      t++;
      if (t == 1) start = 1'b0;
      if (done) nd++;
      else if (nd == 2) loop_drv = 1'b0;
    end
    chk("loop_done_pulses", nd, 3);
    chk("loop_err", err_count, 3'd6);
    chk("loop_fail", fail_vec, 4'b0110);
    chk("loop_pass", pass, 1'b0);
    repeat (3) cycle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
